// File: rtl/scalar_pkg.sv
// Shared widths, opcode encodings and the signed saturation helper
// used by the scalar execute/writeback datapath.
package scalar_pkg;

    localparam int WIDTH  = 12;
    localparam int ADDR_W = 3;
    localparam int FRAC   = 6;

    localparam logic [2:0] OP_MOV  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_IMUL = 3'b100;
    localparam logic [2:0] OP_FADD = 3'b101;
    localparam logic [2:0] OP_FMUL = 3'b110;
    localparam logic [2:0] OP_CMP  = 3'b111;

    // Signed bounds of a WIDTH-bit result, held at double width for comparison
    localparam logic signed [2*WIDTH-1:0] SAT_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] SAT_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] sat_s(input logic signed [2*WIDTH-1:0] v);
        if (v > SAT_MAX)
            return {1'b0, {(WIDTH-1){1'b1}}};
        else if (v < SAT_MIN)
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return v[WIDTH-1:0];
    endfunction

endpackage

// File: rtl/scalar_alu.sv
// Combinational 8-function ALU: integer, saturating signed, Q6.6 fixed-point
// and unsigned compare operations on two register-file sources.
module scalar_alu
    import scalar_pkg::*;
#(
    parameter int WIDTH = scalar_pkg::WIDTH,
    parameter int FRAC  = scalar_pkg::FRAC
) (
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic signed [2*WIDTH-1:0] sa;
    logic signed [2*WIDTH-1:0] sb;
    logic signed [2*WIDTH-1:0] prod_s;
    logic signed [2*WIDTH-1:0] sum_s;
    logic signed [2*WIDTH-1:0] fmul_s;

    // Sign-extend once so every signed path works at double width without overflow
    assign sa     = {{WIDTH{a[WIDTH-1]}}, a};
    assign sb     = {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_s = sa * sb;
    assign sum_s  = sa + sb;
    assign fmul_s = prod_s >>> FRAC;

    always_comb begin
        y = '0;
        unique case (opcode)
            OP_MOV:  y = a;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_MUL:  y = a * b;
            OP_IMUL: y = sat_s(prod_s);
            OP_FADD: y = sat_s(sum_s);
            OP_FMUL: y = sat_s(fmul_s);
            OP_CMP:  y = {{(WIDTH-3){1'b0}}, (a > b), (a < b), (a == b)};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/scalar_datapath.sv
// Scalar execute/writeback datapath: 8-entry register file with two gated
// combinational read ports, the ALU, and the immediate/ALU write-back mux.
module scalar_datapath
    import scalar_pkg::*;
#(
    parameter int WIDTH  = scalar_pkg::WIDTH,
    parameter int ADDR_W = scalar_pkg::ADDR_W,
    parameter int FRAC   = scalar_pkg::FRAC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        opcode,
    input  logic [WIDTH-1:0]  dat,
    input  logic              select,
    input  logic              write,
    input  logic              read2,
    input  logic              read3,
    input  logic [ADDR_W-1:0] adr1,
    input  logic [ADDR_W-1:0] adr2,
    input  logic [ADDR_W-1:0] adr3,
    output logic [WIDTH-1:0]  op1,
    output logic [WIDTH-1:0]  op2,
    output logic [WIDTH-1:0]  op3,
    output logic [WIDTH-1:0]  datain
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0][WIDTH-1:0] regs;

    // No write bypass: reads always see the state before the pending edge
    assign op1    = read2 ? regs[adr2] : '0;
    assign op2    = read3 ? regs[adr3] : '0;
    assign datain = select ? dat : op3;

    scalar_alu #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_alu (
        .opcode (opcode),
        .a      (op1),
        .b      (op2),
        .y      (op3)
    );

    always_ff @(posedge clk) begin
        if (rst)
            regs <= '0;
        else if (write)
            regs[adr1] <= datain;
    end

endmodule

// File: tb/tb_scalar_datapath.sv
// Directed bench for scalar_datapath: reset, immediate loads, every ALU
// function, saturation/wrap boundaries and write/reset control.
module tb_scalar_datapath;
    import scalar_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  opcode;
    logic [11:0] dat;
    logic        select, write, read2, read3;
    logic [2:0]  adr1, adr2, adr3;
    logic [11:0] op1, op2, op3, datain;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    scalar_datapath dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .dat    (dat),
        .select (select),
        .write  (write),
        .read2  (read2),
        .read3  (read3),
        .adr1   (adr1),
        .adr2   (adr2),
        .adr3   (adr3),
        .op1    (op1),
        .op2    (op2),
        .op3    (op3),
        .datain (datain)
    );

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] r, input logic [11:0] exp, input string tag);
        write = 1'b0;
        read2 = 1'b1;
        adr2  = r;
        #1;
        check(tag, op1, exp);
    endtask

    task automatic load(input logic [2:0] r, input logic [11:0] v);
        select = 1'b1;
        write  = 1'b1;
        dat    = v;
        adr1   = r;
        tick();
        write  = 1'b0;
    endtask

    // Compute with sources ra/rb, write to dst, check result and readback
    task automatic alu_wr(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                          input logic [2:0] dst, input logic [11:0] exp, input string tag);
        opcode = op;
        read2  = 1'b1;
        read3  = 1'b1;
        adr2   = ra;
        adr3   = rb;
        select = 1'b0;
        write  = 1'b1;
        adr1   = dst;
        dat    = 12'hABC;
        #1;
        check({tag, "_op3"}, op3, exp);
        check({tag, "_datain"}, datain, exp);
        tick();
        rd(dst, exp, {tag, "_wb"});
    endtask

    task automatic alu_chk(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                           input logic [11:0] exp, input string tag);
        opcode = op;
        write  = 1'b0;
        read2  = 1'b1;
        read3  = 1'b1;
        adr2   = ra;
        adr3   = rb;
        #1;
        check(tag, op3, exp);
    endtask

    initial begin
        rst = 1'b1; opcode = OP_MOV; dat = '0; select = 1'b0; write = 1'b0;
        read2 = 1'b0; read3 = 1'b0; adr1 = '0; adr2 = '0; adr3 = '0;
        tick();
        rst = 1'b0;

        // Reset sweep over both read ports
        read2 = 1'b1; read3 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            adr2 = 3'(i);
            adr3 = 3'(7 - i);
            #1;
            check($sformatf("rst_op1_r%0d", i), op1, 12'h000);
            check($sformatf("rst_op2_r%0d", 7 - i), op2, 12'h000);
        end

        // Immediate load with same-cycle read of the destination
        select = 1'b1; write = 1'b1; dat = 12'd5; adr1 = 3'd0; adr2 = 3'd0;
        #1;
        check("nobypass_old", op1, 12'h000);
        check("imm_datain", datain, 12'd5);
        tick();
        load(3'd1, 12'd3);
        rd(3'd0, 12'd5, "imm_r0");
        rd(3'd1, 12'd3, "imm_r1");

        // Arithmetic with R0=5, R1=3
        alu_wr(OP_ADD,  3'd0, 3'd1, 3'd2, 12'd8,  "add");
        alu_wr(OP_SUB,  3'd0, 3'd1, 3'd3, 12'd2,  "sub");
        alu_wr(OP_MUL,  3'd0, 3'd1, 3'd4, 12'd15, "mul");
        alu_wr(OP_IMUL, 3'd0, 3'd1, 3'd5, 12'd15, "imul");
        alu_wr(OP_FADD, 3'd0, 3'd1, 3'd6, 12'd8,  "fadd");
        alu_wr(OP_FMUL, 3'd0, 3'd1, 3'd7, 12'd0,  "fmul");
        alu_wr(OP_CMP,  3'd0, 3'd1, 3'd2, 12'h004, "cmp_gt");
        alu_chk(OP_CMP, 3'd0, 3'd0, 12'h001, "cmp_eq");
        alu_chk(OP_CMP, 3'd1, 3'd0, 12'h002, "cmp_lt");

        // Boundaries
        load(3'd3, 12'hFFF);
        load(3'd4, 12'h001);
        load(3'd5, 12'h000);
        load(3'd6, 12'h7FF);
        load(3'd7, 12'h002);
        alu_chk(OP_ADD,  3'd3, 3'd4, 12'h000, "add_wrap");
        alu_chk(OP_SUB,  3'd5, 3'd4, 12'hFFF, "sub_wrap");
        alu_chk(OP_IMUL, 3'd6, 3'd7, 12'h7FF, "imul_satpos");
        load(3'd3, 12'h800);
        alu_chk(OP_IMUL, 3'd3, 3'd7, 12'h800, "imul_satneg");
        load(3'd0, 12'h7C0);
        load(3'd1, 12'h080);
        alu_chk(OP_FADD, 3'd0, 3'd1, 12'h7FF, "fadd_sat");
        load(3'd2, 12'h040);
        alu_chk(OP_FMUL, 3'd2, 3'd2, 12'h040, "fmul_one");

        // Read-disabled source feeds zero
        opcode = OP_MOV; read2 = 1'b0; adr2 = 3'd2;
        #1;
        check("rd2off_op1", op1, 12'h000);
        check("rd2off_mov", op3, 12'h000);

        // write=0 leaves state untouched
        select = 1'b1; write = 1'b0; dat = 12'hABC; adr1 = 3'd2;
        tick();
        rd(3'd2, 12'h040, "nowrite_r2");

        // Reset beats a concurrent write
        rst = 1'b1; select = 1'b1; write = 1'b1; dat = 12'h123; adr1 = 3'd1;
        tick();
        rst = 1'b0;
        rd(3'd1, 12'h000, "rst_wins_r1");
        rd(3'd0, 12'h000, "rst_clr_r0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scalar_datapath.md
Name: scalar_datapath

Overview:
- Single-issue scalar execute/writeback datapath: 8x12-bit register file, 2:1 write-data mux and 8-function 12-bit ALU.
- Two sources are read combinationally and fed to the ALU.
- Write-back data is either the ALU result or external immediate data `dat`; it is written on the clock edge.
- Sits under the pipeline control stage, which supplies the opcode, addresses, enables and select.

Parameters:
- WIDTH, 12, datapath/register width in bits.
- ADDR_W, 3, register address width; register file depth is 2**ADDR_W = 8.
- FRAC, 6, fractional bits of the Q6.6 fixed-point format used by FADD/FMUL.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  3  ALU function select.
- dat  input  WIDTH  external/immediate write data.
- select  input  1  1 = write `dat`; 0 = write the ALU result.
- write  input  1  register write enable.
- read2  input  1  read enable for source A.
- read3  input  1  read enable for source B.
- adr1  input  ADDR_W  destination (write) address.
- adr2  input  ADDR_W  source A address.
- adr3  input  ADDR_W  source B address.
- op1  output  WIDTH  source A read data.
- op2  output  WIDTH  source B read data.
- op3  output  WIDTH  ALU result (combinational).
- datain  output  WIDTH  mux output, i.e. the write-back data.

Behaviour:
- Reset: on a rising edge with rst=1, all 8 registers clear to 0. Writes are suppressed that cycle. rst wins over write.
- Reads are combinational:
  - op1 = read2 ? R[adr2] : 0.
  - op2 = read3 ? R[adr3] : 0.
  - No write-to-read bypass: a same-cycle read of adr1 returns the old value; the new value is visible the cycle after the edge.
- Mux: datain = select ? dat : op3. Purely combinational.
- Write: on a rising edge with rst=0 and write=1, R[adr1] <= datain. Latency is 1 cycle. All 8 registers, including R0, are writable.
- ALU, combinational; a = op1, b = op2:
  - 000 MOV: op3 = a.
  - 001 ADD: op3 = (a+b) mod 2^12; wraps.
  - 010 SUB: op3 = (a-b) mod 2^12; wraps.
  - 011 MUL: op3 = low 12 bits of the unsigned 24-bit product.
  - 100 IMUL: signed 24-bit product, saturated to [-2048, 2047].
  - 101 FADD: Q6.6 signed add, saturated to 0x7FF / 0x800.
  - 110 FMUL: Q6.6 signed multiply = (signed a * signed b) >>> FRAC, truncation toward -inf, then saturated to 12-bit signed.
  - 111 CMP: unsigned compare.
    - op3[0] = (a==b), op3[1] = (a<b), op3[2] = (a>b); op3[11:3] = 0.
- op3 is computed for every opcode regardless of select; it is ignored when select=1.
- Read-disabled sources feed 0 into the ALU.
- No flags register and no state other than the register file.

Decomposition:
- Shared package scalar_pkg holds:
  - WIDTH, ADDR_W and FRAC defaults.
  - Opcode localparams: OP_MOV, OP_ADD, OP_SUB, OP_MUL, OP_IMUL, OP_FADD, OP_FMUL, OP_CMP.
  - A saturate-to-12-bit-signed function.
- One natural sub-module, scalar_alu: the combinational ALU.
- Register file and mux stay inline in scalar_datapath.

Test Plan:
- Reset: rst=1 for one edge, then read2=read3=1 sweeping adr2/adr3 over 0..7 -> op1=op2=0 for every register.
- Immediate load: select=1, write=1, dat=5, adr1=0, edge; then dat=3, adr1=1, edge -> R0=5, R1=3. Same-cycle read of adr1 before the edge returns the old value.
- Arithmetic, each with adr2=0, adr3=1, select=0, write=1:
  - ADD to R2 -> 8.
  - SUB to R3 -> 2.
  - MUL to R4 -> 15.
  - IMUL to R5 -> 15.
  - FADD to R6 -> 8.
  - FMUL to R7 -> 0.
- CMP: R0=5 vs R1=3 -> op3=0x004, written to R2. Equal operands -> 0x001. 3 vs 5 -> 0x002.
- Boundaries:
  - ADD 0xFFF+1 -> 0x000 (wrap).
  - SUB 0-1 -> 0xFFF.
  - IMUL 0x7FF*2 -> 0x7FF (saturated).
  - FADD 0x7C0+0x080 -> 0x7FF.
  - FMUL 0x040*0x040 (1.0*1.0) -> 0x040.
  - read2=0 -> op1=0 and MOV yields 0.
- Control: write=0 with select=1 -> no register changes. rst=1 together with write=1 -> register stays 0.
